// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets inside the 64 KiB window, default base
// address, register select encoding and the byte-lane merge helper.
package clint_pkg;

    localparam logic [31:0] clint_base_default = 32'h0200_0000;

    localparam logic [15:0] clint_msip_off        = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_lo_off = 16'h4000;
    localparam logic [15:0] clint_mtimecmp_hi_off = 16'h4004;
    localparam logic [15:0] clint_mtime_lo_off    = 16'hBFF8;
    localparam logic [15:0] clint_mtime_hi_off    = 16'hBFFC;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } clint_reg_e;

    function automatic clint_reg_e clint_decode(input logic [15:0] off);
        clint_reg_e r;
        case (off)
            clint_msip_off:        r = REG_MSIP;
            clint_mtimecmp_lo_off: r = REG_CMP_LO;
            clint_mtimecmp_hi_off: r = REG_CMP_HI;
            clint_mtime_lo_off:    r = REG_MTIME_LO;
            clint_mtime_hi_off:    r = REG_MTIME_HI;
            default:               r = REG_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_if.sv
// CPU data-bus handshake as seen by the CLINT: one-cycle request strobe in,
// one-cycle ready strobe with registered read data out.
interface clint_if;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;

    modport master (
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        input  memory_rdata, memory_ready
    );

    modport slave (
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        output memory_rdata, memory_ready
    );
endinterface

// File: rtl/clint_tick.sv
// Prescaler for mtime: counts 0..clint_prescale-1 and flags the cycle in which
// the counter wraps back to 0.
module clint_tick #(
    parameter int unsigned clint_prescale = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CNT_W = (clint_prescale > 1) ? $clog2(clint_prescale) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clint_prescale - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // With clint_prescale == 1 the counter sits at 0 and every cycle is a tick.
    always_comb begin
        tick_o = (cnt_q == CNT_LAST);
        cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and the free-running 64-bit mtime behind
// a single-cycle-latency bus slave, plus the timer/software interrupt lines.
module clint
    import clint_pkg::*;
#(
    parameter int unsigned clint_prescale = 1,
    parameter logic [31:0] clint_base     = clint_base_default
) (
    input  logic        clk,
    input  logic        rst,
    clint_if.slave      bus,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    logic        tick;
    logic        data_acc;
    logic        wr_en;
    logic [15:0] offset;
    clint_reg_e  sel;
    logic [31:0] rd_val;

    logic        msip_q, msip_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        mtip_q, mtip_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    clint_tick #(.clint_prescale(clint_prescale)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // The window is 64 KiB, so the low half of the address difference is enough.
    assign offset   = bus.memory_addr[15:0] - clint_base[15:0];
    assign data_acc = bus.memory_valid & ~bus.memory_instr;
    assign wr_en    = data_acc & (|bus.memory_wstrb);
    assign sel      = data_acc ? clint_decode(offset) : REG_NONE;

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_MSIP:     rd_val = {31'b0, msip_q};
            REG_CMP_LO:   rd_val = mtimecmp_q[31:0];
            REG_CMP_HI:   rd_val = mtimecmp_q[63:32];
            REG_MTIME_LO: rd_val = mtime_q[31:0];
            REG_MTIME_HI: rd_val = mtime_q[63:32];
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

        if (wr_en) begin
            case (sel)
                REG_MSIP: begin
                    if (bus.memory_wstrb[0]) msip_d = bus.memory_wdata[0];
                end
                REG_CMP_LO: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],
                                                           bus.memory_wdata, bus.memory_wstrb);
                REG_CMP_HI: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32],
                                                           bus.memory_wdata, bus.memory_wstrb);
                // A software write to mtime overrides the tick; no carry between halves.
                REG_MTIME_LO: mtime_d = {mtime_q[63:32],
                                         byte_merge(mtime_q[31:0], bus.memory_wdata, bus.memory_wstrb)};
                REG_MTIME_HI: mtime_d = {byte_merge(mtime_q[63:32], bus.memory_wdata, bus.memory_wstrb),
                                         mtime_q[31:0]};
                default: ;
            endcase
        end

        mtip_d  = (mtime_q >= mtimecmp_q);
        ready_d = bus.memory_valid;
        rdata_d = bus.memory_valid ? rd_val : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            mtip_q     <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= mtip_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.memory_ready = ready_q;
    assign bus.memory_rdata = rdata_q;
    assign clint_msip       = msip_q;
    assign clint_mtip       = mtip_q;
    assign clint_mtime      = mtime_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: one instance with prescale 4 for the idle timer rate,
// one with prescale 1 for compare, collision, protocol and reset corner cases.
module tb_clint;
    import clint_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic clk  = 1'b0;
    logic rst4 = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    clint_if b4();
    clint_if b1();

    logic        msip4, mtip4, msip1, mtip1;
    logic [63:0] mtime4, mtime1;

    clint #(.clint_prescale(4), .clint_base(BASE)) u_dut4 (
        .clk(clk), .rst(rst4), .bus(b4),
        .clint_msip(msip4), .clint_mtip(mtip4), .clint_mtime(mtime4)
    );

    clint #(.clint_prescale(1), .clint_base(BASE)) u_dut1 (
        .clk(clk), .rst(rst1), .bus(b1),
        .clint_msip(msip1), .clint_mtip(mtip1), .clint_mtime(mtime1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [15:0] off;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        ins;
        logic [31:0] exp_rd;
        logic        exp_msip;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input bit d1, input logic [15:0] off, input logic [31:0] wd,
                         input logic [3:0] ws, input logic ins);
        if (d1) begin
            b1.memory_valid = 1'b1; b1.memory_instr = ins; b1.memory_addr = BASE + {16'h0, off};
            b1.memory_wdata = wd;   b1.memory_wstrb = ws;
        end else begin
            b4.memory_valid = 1'b1; b4.memory_instr = ins; b4.memory_addr = BASE + {16'h0, off};
            b4.memory_wdata = wd;   b4.memory_wstrb = ws;
        end
    endtask

    task automatic idle();
        b1.memory_valid = 1'b0; b1.memory_instr = 1'b0; b1.memory_addr = '0;
        b1.memory_wdata = '0;   b1.memory_wstrb = '0;
        b4.memory_valid = 1'b0; b4.memory_instr = 1'b0; b4.memory_addr = '0;
        b4.memory_wdata = '0;   b4.memory_wstrb = '0;
    endtask

    task automatic xfer(input bit d1, input logic [15:0] off, input logic [31:0] wd,
                        input logic [3:0] ws, input logic ins,
                        output logic [31:0] rd, output logic rdy);
        @(negedge clk);
        drive(d1, off, wd, ws, ins);
        @(negedge clk);
        idle();
        rdy = d1 ? b1.memory_ready : b4.memory_ready;
        rd  = d1 ? b1.memory_rdata : b4.memory_rdata;
    endtask

    logic [31:0] rd;
    logic        rdy;

    initial begin
        idle();
        vt[0]  = '{16'h4000, 32'h1122_3344, 4'hF, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vt[1]  = '{16'h4000, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h1122_3344, 1'b0};
        vt[2]  = '{16'h4000, 32'h0,         4'h0, 1'b0, 32'h11BB_33DD, 1'b0};
        vt[3]  = '{16'h4004, 32'h0,         4'h0, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vt[4]  = '{16'h1000, 32'h0,         4'h0, 1'b0, 32'h0,         1'b0};
        vt[5]  = '{16'h1000, 32'h1234_5678, 4'hF, 1'b0, 32'h0,         1'b0};
        vt[6]  = '{16'h4000, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0};
        vt[7]  = '{16'h4000, 32'h0,         4'hF, 1'b1, 32'h0,         1'b0};
        vt[8]  = '{16'h4000, 32'h0,         4'h0, 1'b0, 32'h11BB_33DD, 1'b0};
        vt[9]  = '{16'h0000, 32'hFFFF_FFFF, 4'hE, 1'b0, 32'h0,         1'b0};
        vt[10] = '{16'h0000, 32'h0,         4'h0, 1'b0, 32'h0,         1'b0};
        vt[11] = '{16'h0000, 32'h3,         4'hF, 1'b0, 32'h0,         1'b1};
        vt[12] = '{16'h0000, 32'h0,         4'h0, 1'b0, 32'h1,         1'b1};
        vt[13] = '{16'h0000, 32'h0,         4'hF, 1'b0, 32'h1,         1'b0};
        vt[14] = '{16'h0000, 32'h0,         4'h0, 1'b0, 32'h0,         1'b0};

        // ---- prescale 4: reset values, idle rate, msip ----
        @(negedge clk);
        chk("rst4_ready", b4.memory_ready, 0);
        chk("rst4_rdata", b4.memory_rdata, 0);
        chk("rst4_mtime", mtime4, 0);
        chk("rst4_mtip",  mtip4, 0);
        chk("rst4_msip",  msip4, 0);
        rst4 = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("p4_mtime_40clk", mtime4, 10);
        chk("p4_mtip_idle", mtip4, 0);
        chk("p4_msip_idle", msip4, 0);

        xfer(1'b0, 16'h0000, 32'h1, 4'hF, 1'b0, rd, rdy);
        chk("p4_msip_wr_ready", rdy, 1);
        chk("p4_msip_set", msip4, 1);
        xfer(1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, rd, rdy);
        chk("p4_msip_rd_ready", rdy, 1);
        chk("p4_msip_rd", rd, 32'h1);
        xfer(1'b0, 16'h0000, 32'h0, 4'hF, 1'b0, rd, rdy);
        chk("p4_msip_clr", msip4, 0);

        // ---- prescale 1: mtip rise after mtime reaches mtimecmp ----
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk); drive(1'b1, 16'h4004, 32'h0,  4'hF, 1'b0);
        @(negedge clk); drive(1'b1, 16'h4000, 32'd20, 4'hF, 1'b0);
        @(negedge clk); drive(1'b1, 16'hBFF8, 32'h0,  4'hF, 1'b0);
        @(negedge clk); drive(1'b1, 16'hBFFC, 32'h0,  4'hF, 1'b0);
        @(negedge clk); idle();
        chk("mtime_cleared", mtime1, 0);
        repeat (20) @(negedge clk);
        chk("mtime_at_20", mtime1, 20);
        chk("mtip_not_yet", mtip1, 0);
        @(negedge clk);
        chk("mtip_rise", mtip1, 1);

        // Raising mtimecmp clears mtip one cycle after the register update
        drive(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF, 1'b0);
        @(negedge clk); idle();
        chk("mtip_fall_latency", mtip1, 1);
        @(negedge clk);
        chk("mtip_fall", mtip1, 0);
        drive(1'b1, 16'h4004, 32'hFFFF_FFFF, 4'hF, 1'b0);
        @(negedge clk); idle();
        @(negedge clk);
        chk("mtip_cmp_ones", mtip1, 0);

        // mtime write in a tick cycle wins; next tick wraps to 0
        drive(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0);
        @(negedge clk); drive(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0);
        @(negedge clk); idle();
        chk("wrap_no_inc", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_mtip_pre", mtip1, 0);
        @(negedge clk);
        chk("wrap_zero", mtime1, 0);
        chk("wrap_mtip_eq", mtip1, 1);
        @(negedge clk);
        chk("wrap_mtip_clr", mtip1, 0);

        // Back-to-back: write lo, write hi, read lo, read hi on consecutive cycles
        drive(1'b1, 16'hBFF8, 32'h0000_0100, 4'hF, 1'b0);
        @(negedge clk);
        chk("b2b_wr_lo_ready", b1.memory_ready, 1);
        drive(1'b1, 16'hBFFC, 32'h1234_5678, 4'hF, 1'b0);
        @(negedge clk);
        chk("b2b_wr_hi_ready", b1.memory_ready, 1);
        drive(1'b1, 16'hBFF8, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("b2b_rd_lo_ready", b1.memory_ready, 1);
        chk("b2b_rd_lo", b1.memory_rdata, 32'h0000_0100);
        drive(1'b1, 16'hBFFC, 32'h0, 4'h0, 1'b0);
        @(negedge clk); idle();
        chk("b2b_rd_hi_ready", b1.memory_ready, 1);
        chk("b2b_rd_hi", b1.memory_rdata, 32'h1234_5678);
        chk("b2b_mtime", mtime1, 64'h1234_5678_0000_0102);
        @(negedge clk);
        chk("b2b_ready_drop", b1.memory_ready, 0);
        chk("b2b_rdata_zero", b1.memory_rdata, 0);

        // Table-driven register accesses
        for (int i = 0; i < 15; i++) begin
            xfer(1'b1, vt[i].off, vt[i].wd, vt[i].ws, vt[i].ins, rd, rdy);
            chk($sformatf("vec%0d_ready", i), rdy, 1);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_msip", i), msip1, vt[i].exp_msip);
        end

        // Reset with a request in flight: no ready pulse, everything back to reset values
        xfer(1'b1, 16'h0000, 32'h1, 4'hF, 1'b0, rd, rdy);
        chk("pre_rst_msip", msip1, 1);
        @(negedge clk);
        drive(1'b1, 16'h0000, 32'h0, 4'h0, 1'b0);
        #2 rst1 = 1'b1;
        @(negedge clk); idle();
        chk("rst_drop_ready", b1.memory_ready, 0);
        chk("rst_drop_rdata", b1.memory_rdata, 0);
        chk("rst_msip", msip1, 0);
        chk("rst_mtip", mtip1, 0);
        chk("rst_mtime", mtime1, 0);
        @(negedge clk);
        chk("rst_ready_hold", b1.memory_ready, 0);
        rst1 = 1'b0;
        @(negedge clk);
        chk("post_rst_mtime", mtime1, 1);
        xfer(1'b1, 16'h4000, 32'h0, 4'h0, 1'b0, rd, rdy);
        chk("post_rst_cmp_lo", rd, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clint.md
Name: clint

Overview:
- Core-local interruptor on the CPU data bus, directly downstream of the cpu on the same memory_* handshake that feeds main memory.
- Holds the 64-bit machine timer (mtime), the timer compare register (mtimecmp) and the software-interrupt bit (msip).
- Drives the machine timer and software interrupt lines back into the cpu.
- An external address decoder gates memory_valid so that only accesses inside the CLINT window reach this block.

Parameters:
- clint_prescale, 1, number of clk cycles per mtime increment; must be >= 1.
- clint_base, 32'h02000000, base address of the 64 KiB register window.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- memory_valid  input  1  request strobe (one-cycle pulse per request)
- memory_instr  input  1  request is an instruction fetch
- memory_addr  input  32  byte address
- memory_wdata  input  32  write data
- memory_wstrb  input  4  byte write enables; 0 means read
- memory_rdata  output  32  read data, valid while memory_ready=1
- memory_ready  output  1  one-cycle response strobe
- clint_msip  output  1  machine software interrupt pending
- clint_mtip  output  1  machine timer interrupt pending
- clint_mtime  output  64  current mtime, for time/timeh CSR reads

Behaviour:
- Offset = memory_addr - clint_base, using bits [15:0].
- Register map:
  - 0x0000: msip; bit0 is R/W, bits 31:1 read as 0.
  - 0x4000: mtimecmp[31:0].
  - 0x4004: mtimecmp[63:32].
  - 0xBFF8: mtime[31:0].
  - 0xBFFC: mtime[63:32].
  - Any other offset reads 0 and ignores writes, but is still acknowledged.
- Handshake:
  - A request is accepted in every cycle where memory_valid=1.
  - memory_ready=1 exactly one cycle later, for one cycle only, with memory_rdata registered in that cycle.
  - Back-to-back requests on consecutive cycles each produce their own ready pulse; there are no stalls.
  - memory_rdata=0 whenever memory_ready=0.
- Instruction fetch (memory_instr=1): acknowledged with rdata=0; any write is ignored.
- Writes: each byte lane is written where its wstrb bit is 1. Read data returns the value before any write accepted in the same cycle.
- Prescaler:
  - A counter counts 0..clint_prescale-1.
  - A tick is generated on the wrap from clint_prescale-1 back to 0.
  - On a tick, mtime increments by 1 with 64-bit wrap-around (FFFF_FFFF_FFFF_FFFF -> 0).
- Write collisions:
  - A write to either mtime half in a tick cycle wins; no increment occurs in that cycle.
  - The untouched half keeps its value; there is no carry from the lower half.
- clint_mtip:
  - Registered value of (mtime >= mtimecmp), unsigned 64-bit compare on the post-update values.
  - Reflects a change one cycle after the mtime or mtimecmp update.
  - Level signal, cleared only by raising mtimecmp or writing mtime.
- clint_msip = msip bit0, registered; no extra latency beyond the write cycle.
- clint_mtime = mtime register.
- Reset (asynchronous, while rst=1):
  - mtime=0, mtimecmp=FFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - memory_ready=0, memory_rdata=0, clint_mtip=0, clint_msip=0.
  - A request pending at reset assertion is dropped with no ready pulse.

Decomposition:
- Shared package holds:
  - CLINT offset constants: clint_msip_off, clint_mtimecmp_lo_off/hi_off, clint_mtime_lo_off/hi_off.
  - Default clint_base.
- One sub-module, clint_tick: prescaler counter that outputs a single-cycle tick, parameterised by clint_prescale. It is instantiated once.
- Register file, byte-lane write logic, compare and bus response live in clint.

Test Plan:
- Reset then idle, clint_prescale=4: after 40 clk, mtime=10; clint_mtip=0; clint_msip=0.
- Write 0x0000 wdata=1 wstrb=F: ready one cycle later; clint_msip=1. Read 0x0000 -> rdata=0x00000001. Write 0 -> clint_msip=0.
- clint_prescale=1:
  - mtimecmp_hi=0, mtimecmp_lo=20 -> clint_mtip rises one cycle after mtime reaches 20.
  - Writing mtimecmp_lo=0xFFFFFFFF, then mtimecmp_hi=0xFFFFFFFF (mtimecmp=all ones) -> clint_mtip falls on the next cycle.
- Write mtime_lo=0xFFFFFFFF, mtime_hi=0xFFFFFFFF with a tick in the same cycle as the hi write -> no increment in that cycle; the next tick wraps mtime to 0.
- Byte strobes: mtimecmp_lo=0x11223344, then write wdata=0xAABBCCDD wstrb=4'b0101 -> readback 0x11BB33DD.
- Protocol corner cases:
  - Back-to-back reads of 0xBFF8 and 0xBFFC -> two consecutive ready pulses.
  - Unmapped offset 0x1000 -> rdata=0.
  - memory_instr=1 read -> rdata=0.
  - rst asserted in the cycle after a valid -> no ready pulse; all outputs return to their reset values.
